// File: rtl/instr_mem_controller_pkg.sv
// rtl/instr_mem_controller_pkg.sv - shared widths and FSM encoding for the instruction memory controller
package instr_mem_controller_pkg;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 512;
    localparam int LEN_W     = ADDR_W + 1;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

endpackage

// File: rtl/instr_mem_controller_if.sv
// rtl/instr_mem_controller_if.sv - loader, fetch and memory-side signals of the controller
interface instr_mem_controller_if;
    import instr_mem_controller_pkg::*;

    logic              ClrReq;
    logic              LoadStart;
    logic [ADDR_W-1:0] LoadBase;
    logic [LEN_W-1:0]  LoadLen;
    logic              LoadValid;
    logic [DATA_W-1:0] LoadData;
    logic              LoadReady;
    logic              LoadDone;
    logic              LoadErr;
    logic              FetchReq;
    logic [ADDR_W-1:0] FetchAddr;
    logic              FetchGnt;
    logic              FetchValid;
    logic [DATA_W-1:0] FetchData;
    logic              Busy;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WriteData;
    logic              WAIM;
    logic              RAIM;
    logic              InitAIM;
    logic [DATA_W-1:0] ReadData;

    // master: the system around the controller (loader, fetch unit, memory)
    modport master (
        output ClrReq, LoadStart, LoadBase, LoadLen, LoadValid, LoadData,
               FetchReq, FetchAddr, ReadData,
        input  LoadReady, LoadDone, LoadErr, FetchGnt, FetchValid, FetchData,
               Busy, Addr, WriteData, WAIM, RAIM, InitAIM
    );

    modport slave (
        input  ClrReq, LoadStart, LoadBase, LoadLen, LoadValid, LoadData,
               FetchReq, FetchAddr, ReadData,
        output LoadReady, LoadDone, LoadErr, FetchGnt, FetchValid, FetchData,
               Busy, Addr, WriteData, WAIM, RAIM, InitAIM
    );

endinterface

// File: rtl/instr_fetch_pipe.sv
// rtl/instr_fetch_pipe.sv - two-stage read strobe to fetch-valid pipeline with data capture
module instr_fetch_pipe #(
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              raim,
    input  logic [DATA_W-1:0] rd_data,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data
);

    logic rd_pending;

    // memory returns ReadData one edge after RAIM; capture it on the following edge
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            rd_pending  <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
        end else begin
            rd_pending  <= raim;
            fetch_valid <= rd_pending;
            if (rd_pending)
                fetch_data <= rd_data;
        end
    end

endmodule

// File: rtl/instr_mem_controller.sv
// rtl/instr_mem_controller.sv - instruction memory controller: clear, program load and fetch arbitration
module instr_mem_controller #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic                         Clk,
    input  logic                         Rst,
    instr_mem_controller_if.slave        bus
);
    import instr_mem_controller_pkg::*;

    localparam int CNT_W = ADDR_W + 1;

    state_t             state;
    logic [ADDR_W-1:0]  ptr;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W:0]     load_end;
    logic               load_bad;
    logic               fetch_gnt;
    logic               load_accept;

    assign load_end    = {2'b00, bus.LoadBase} + {1'b0, bus.LoadLen};
    assign load_bad    = (bus.LoadLen == '0) || (load_end > (CNT_W + 1)'(MEM_DEPTH));
    assign fetch_gnt   = bus.FetchReq && (state == ST_IDLE) && !bus.ClrReq && !bus.LoadStart;
    // a clear request in LOAD wins over a byte offered in the same cycle
    assign load_accept = (state == ST_LOAD) && bus.LoadValid && !bus.ClrReq;

    assign bus.FetchGnt  = fetch_gnt;
    assign bus.LoadReady = (state == ST_LOAD);
    assign bus.Busy      = (state != ST_IDLE);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state         <= ST_CLEAR;
            ptr           <= '0;
            cnt           <= '0;
            bus.Addr      <= '0;
            bus.WriteData <= '0;
            bus.WAIM      <= 1'b0;
            bus.RAIM      <= 1'b0;
            bus.InitAIM   <= 1'b0;
            bus.LoadDone  <= 1'b0;
            bus.LoadErr   <= 1'b0;
        end else begin
            bus.WAIM     <= 1'b0;
            bus.RAIM     <= 1'b0;
            bus.InitAIM  <= 1'b0;
            bus.LoadDone <= 1'b0;
            bus.LoadErr  <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    bus.InitAIM <= 1'b1;
                    state       <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.ClrReq) begin
                        state <= ST_CLEAR;
                    end else if (bus.LoadStart) begin
                        if (load_bad) begin
                            bus.LoadErr <= 1'b1;
                        end else begin
                            ptr   <= bus.LoadBase;
                            cnt   <= bus.LoadLen;
                            state <= ST_LOAD;
                        end
                    end else if (fetch_gnt) begin
                        bus.Addr <= bus.FetchAddr;
                        bus.RAIM <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (bus.ClrReq) begin
                        bus.LoadErr <= 1'b1;
                        state       <= ST_CLEAR;
                    end else if (load_accept) begin
                        bus.Addr      <= ptr;
                        bus.WriteData <= bus.LoadData;
                        bus.WAIM      <= 1'b1;
                        ptr           <= ptr + 1'b1;
                        cnt           <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            bus.LoadDone <= 1'b1;
                            state        <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    instr_fetch_pipe #(
        .DATA_W (DATA_W)
    ) u_fetch_pipe (
        .Clk         (Clk),
        .Rst         (Rst),
        .raim        (bus.RAIM),
        .rd_data     (bus.ReadData),
        .fetch_valid (bus.FetchValid),
        .fetch_data  (bus.FetchData)
    );

endmodule

// File: tb/tb_instr_mem_controller.sv
// tb/tb_instr_mem_controller.sv - directed self-checking bench for instr_mem_controller
module tb_instr_mem_controller;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    instr_mem_controller_if bus();

    instr_mem_controller dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem [0:511];
    int tests = 0;
    int fails = 0;
    int init_cnt = 0, waim_cnt = 0, fv_cnt = 0, err_cnt = 0, done_cnt = 0, overlap_cnt = 0;

    // memory model: synchronous clear/write, read data registered one edge after RAIM
    always @(posedge Clk) begin
        if (bus.InitAIM) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
        end else if (bus.WAIM) begin
            mem[bus.Addr] <= bus.WriteData;
        end
        if (bus.RAIM) bus.ReadData <= mem[bus.Addr];
    end

    always @(negedge Clk) begin
        if (bus.InitAIM === 1'b1) init_cnt++;
        if (bus.WAIM === 1'b1) waim_cnt++;
        if (bus.FetchValid === 1'b1) fv_cnt++;
        if (bus.LoadErr === 1'b1) err_cnt++;
        if (bus.LoadDone === 1'b1) done_cnt++;
        if (int'(bus.WAIM) + int'(bus.RAIM) + int'(bus.InitAIM) > 1) overlap_cnt++;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        tests++;
        if ({bus.InitAIM, bus.WAIM, bus.RAIM, bus.FetchValid, bus.LoadDone, bus.LoadErr} !== 6'b0) begin
            fails++;
            $display("FAIL reset_strobes got %b want 000000",
                     {bus.InitAIM, bus.WAIM, bus.RAIM, bus.FetchValid, bus.LoadDone, bus.LoadErr});
        end
        tests++;
        if ({bus.Addr, bus.WriteData, bus.FetchData} !== 25'h0) begin
            fails++;
            $display("FAIL reset_data addr=%h wd=%h fd=%h want 0", bus.Addr, bus.WriteData, bus.FetchData);
        end
        tests++;
        if (bus.Busy !== 1'b1 || bus.LoadReady !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy busy=%b ready=%b want 1/0", bus.Busy, bus.LoadReady);
        end
        Rst = 1'b1;
        init_cnt = 0;
        tick();
        tests++;
        if (bus.InitAIM !== 1'b1 || bus.Busy !== 1'b0) begin
            fails++;
            $display("FAIL release_init init=%b busy=%b want 1/0", bus.InitAIM, bus.Busy);
        end
        tick();
        tick();
        tests++;
        if (init_cnt !== 1) begin
            fails++;
            $display("FAIL release_init_count got %0d want 1", init_cnt);
        end
        bus.FetchReq = 1'b1;
        bus.FetchAddr = 9'h000;
        #1;
        tests++;
        if (bus.FetchGnt !== 1'b1) begin
            fails++;
            $display("FAIL gnt_follows_req got %b want 1", bus.FetchGnt);
        end
        bus.FetchReq = 1'b0;
        #1;
        tests++;
        if (bus.FetchGnt !== 1'b0) begin
            fails++;
            $display("FAIL gnt_drops got %b want 0", bus.FetchGnt);
        end
    endtask

    task automatic test_load_ok();
        int done0;
        done0 = done_cnt;
        bus.LoadStart = 1'b1;
        bus.LoadBase = 9'h1FE;
        bus.LoadLen = 10'd2;
        tick();
        bus.LoadStart = 1'b0;
        tests++;
        if (bus.Busy !== 1'b1 || bus.LoadReady !== 1'b1) begin
            fails++;
            $display("FAIL load_enter busy=%b ready=%b want 1/1", bus.Busy, bus.LoadReady);
        end
        bus.LoadValid = 1'b1;
        bus.LoadData = 8'hA5;
        tick();
        tests++;
        if (bus.WAIM !== 1'b1 || bus.Addr !== 9'h1FE || bus.WriteData !== 8'hA5 || bus.LoadDone !== 1'b0) begin
            fails++;
            $display("FAIL load_byte0 waim=%b addr=%h wd=%h done=%b want 1/1fe/a5/0",
                     bus.WAIM, bus.Addr, bus.WriteData, bus.LoadDone);
        end
        bus.LoadData = 8'h5A;
        tick();
        tests++;
        if (bus.WAIM !== 1'b1 || bus.Addr !== 9'h1FF || bus.WriteData !== 8'h5A || bus.LoadDone !== 1'b1) begin
            fails++;
            $display("FAIL load_byte1 waim=%b addr=%h wd=%h done=%b want 1/1ff/5a/1",
                     bus.WAIM, bus.Addr, bus.WriteData, bus.LoadDone);
        end
        tests++;
        if (bus.LoadReady !== 1'b0 || bus.Busy !== 1'b0) begin
            fails++;
            $display("FAIL load_exit ready=%b busy=%b want 0/0", bus.LoadReady, bus.Busy);
        end
        bus.LoadValid = 1'b0;
        bus.FetchReq = 1'b1;
        bus.FetchAddr = 9'h1FF;
        #1;
        tests++;
        if (bus.FetchGnt !== 1'b1) begin
            fails++;
            $display("FAIL fetch1ff_gnt got %b want 1", bus.FetchGnt);
        end
        tick();
        bus.FetchReq = 1'b0;
        tests++;
        if (bus.RAIM !== 1'b1 || bus.Addr !== 9'h1FF || bus.WAIM !== 1'b0) begin
            fails++;
            $display("FAIL fetch1ff_raim raim=%b addr=%h waim=%b want 1/1ff/0", bus.RAIM, bus.Addr, bus.WAIM);
        end
        tick();
        tests++;
        if (bus.FetchValid !== 1'b0 || bus.RAIM !== 1'b0 || bus.Addr !== 9'h1FF) begin
            fails++;
            $display("FAIL fetch1ff_early fv=%b raim=%b addr=%h want 0/0/1ff", bus.FetchValid, bus.RAIM, bus.Addr);
        end
        tick();
        tests++;
        if (bus.FetchValid !== 1'b1 || bus.FetchData !== 8'h5A) begin
            fails++;
            $display("FAIL fetch1ff_data fv=%b data=%h want 1/5a", bus.FetchValid, bus.FetchData);
        end
        tick();
        tests++;
        if (bus.FetchValid !== 1'b0 || done_cnt - done0 !== 1) begin
            fails++;
            $display("FAIL fetch1ff_end fv=%b done_pulses=%0d want 0/1", bus.FetchValid, done_cnt - done0);
        end
    endtask

    task automatic test_load_err();
        logic [8:0] bases [2] = '{9'h1FF, 9'h000};
        logic [9:0] lens  [2] = '{10'd2, 10'd0};
        int waim0;
        waim0 = waim_cnt;
        for (int k = 0; k < 2; k++) begin
            bus.LoadStart = 1'b1;
            bus.LoadBase = bases[k];
            bus.LoadLen = lens[k];
            tick();
            bus.LoadStart = 1'b0;
            tests++;
            if (bus.LoadErr !== 1'b1 || bus.Busy !== 1'b0 || bus.WAIM !== 1'b0) begin
                fails++;
                $display("FAIL load_err%0d err=%b busy=%b waim=%b want 1/0/0", k, bus.LoadErr, bus.Busy, bus.WAIM);
            end
            tick();
            tests++;
            if (bus.LoadErr !== 1'b0 || bus.Busy !== 1'b0) begin
                fails++;
                $display("FAIL load_err%0d_after err=%b busy=%b want 0/0", k, bus.LoadErr, bus.Busy);
            end
        end
        tests++;
        if (waim_cnt !== waim0) begin
            fails++;
            $display("FAIL load_err_nowrite waim pulses=%0d want 0", waim_cnt - waim0);
        end
    endtask

    task automatic test_priority();
        bus.ClrReq = 1'b1;
        bus.FetchReq = 1'b1;
        bus.FetchAddr = 9'h1FE;
        #1;
        tests++;
        if (bus.FetchGnt !== 1'b0) begin
            fails++;
            $display("FAIL prio_clr_gnt got %b want 0", bus.FetchGnt);
        end
        bus.ClrReq = 1'b0;
        bus.LoadStart = 1'b1;
        bus.LoadBase = 9'h010;
        bus.LoadLen = 10'd1;
        #1;
        tests++;
        if (bus.FetchGnt !== 1'b0) begin
            fails++;
            $display("FAIL prio_load_gnt got %b want 0", bus.FetchGnt);
        end
        tick();
        bus.LoadStart = 1'b0;
        #1;
        tests++;
        if (bus.Busy !== 1'b1 || bus.RAIM !== 1'b0 || bus.FetchGnt !== 1'b0) begin
            fails++;
            $display("FAIL prio_in_load busy=%b raim=%b gnt=%b want 1/0/0", bus.Busy, bus.RAIM, bus.FetchGnt);
        end
        bus.LoadValid = 1'b1;
        bus.LoadData = 8'h3C;
        tick();
        bus.LoadValid = 1'b0;
        tests++;
        if (bus.LoadDone !== 1'b1 || bus.FetchGnt !== 1'b1) begin
            fails++;
            $display("FAIL prio_after_done done=%b gnt=%b want 1/1", bus.LoadDone, bus.FetchGnt);
        end
        tick();
        bus.FetchReq = 1'b0;
        tests++;
        if (bus.RAIM !== 1'b1 || bus.Addr !== 9'h1FE) begin
            fails++;
            $display("FAIL prio_fetch_raim raim=%b addr=%h want 1/1fe", bus.RAIM, bus.Addr);
        end
        tick();
        tick();
        tests++;
        if (bus.FetchValid !== 1'b1 || bus.FetchData !== 8'hA5) begin
            fails++;
            $display("FAIL prio_fetch_data fv=%b data=%h want 1/a5", bus.FetchValid, bus.FetchData);
        end
        tick();
    endtask

    task automatic test_back_to_back(input logic [8:0] a0, input logic [8:0] a1, input logic [8:0] a2,
                                     input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                                     input string tag);
        logic [8:0] addrs [3];
        logic [7:0] exps  [3];
        addrs = '{a0, a1, a2};
        exps  = '{e0, e1, e2};
        for (int i = 0; i < 6; i++) begin
            bus.FetchReq = (i < 3);
            if (i < 3) bus.FetchAddr = addrs[i];
            tick();
            if (i >= 2) begin
                tests++;
                if (bus.FetchValid !== (i <= 4) || ((i <= 4) && bus.FetchData !== exps[(i <= 4) ? i - 2 : 0])) begin
                    fails++;
                    $display("FAIL b2b_%s_%0d fv=%b data=%h want %b/%h", tag, i, bus.FetchValid, bus.FetchData,
                             (i <= 4), exps[(i <= 4) ? i - 2 : 0]);
                end
            end
        end
    endtask

    task automatic test_clear_abort();
        logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};
        int done0;
        done0 = done_cnt;
        bus.LoadStart = 1'b1;
        bus.LoadBase = 9'h020;
        bus.LoadLen = 10'd8;
        tick();
        bus.LoadStart = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.LoadValid = 1'b1;
            bus.LoadData = bytes[k];
            tick();
        end
        tests++;
        if (bus.WAIM !== 1'b1 || bus.Addr !== 9'h022 || bus.WriteData !== 8'h33) begin
            fails++;
            $display("FAIL abort_byte2 waim=%b addr=%h wd=%h want 1/022/33", bus.WAIM, bus.Addr, bus.WriteData);
        end
        bus.LoadValid = 1'b0;
        bus.ClrReq = 1'b1;
        init_cnt = 0;
        tick();
        bus.ClrReq = 1'b0;
        tests++;
        if (bus.LoadErr !== 1'b1 || bus.Busy !== 1'b1 || bus.InitAIM !== 1'b0) begin
            fails++;
            $display("FAIL abort_err err=%b busy=%b init=%b want 1/1/0", bus.LoadErr, bus.Busy, bus.InitAIM);
        end
        tick();
        tests++;
        if (bus.InitAIM !== 1'b1 || bus.Busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_init init=%b busy=%b want 1/0", bus.InitAIM, bus.Busy);
        end
        test_back_to_back(9'h020, 9'h021, 9'h022, 8'h00, 8'h00, 8'h00, "cleared");
        tests++;
        if (init_cnt !== 1 || done_cnt !== done0) begin
            fails++;
            $display("FAIL abort_counts init=%0d done=%0d want 1/0", init_cnt, done_cnt - done0);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int fv0, err0, done0;
        bus.FetchReq = 1'b1;
        bus.FetchAddr = 9'h010;
        tick();
        bus.FetchReq = 1'b0;
        Rst = 1'b0;
        fv0 = fv_cnt;
        err0 = err_cnt;
        done0 = done_cnt;
        tick();
        tests++;
        if ({bus.InitAIM, bus.WAIM, bus.RAIM, bus.FetchValid, bus.LoadDone, bus.LoadErr} !== 6'b0 ||
            {bus.Addr, bus.WriteData, bus.FetchData} !== 25'h0) begin
            fails++;
            $display("FAIL midreset_outputs strobes=%b addr=%h wd=%h fd=%h want all 0",
                     {bus.InitAIM, bus.WAIM, bus.RAIM, bus.FetchValid, bus.LoadDone, bus.LoadErr},
                     bus.Addr, bus.WriteData, bus.FetchData);
        end
        tick();
        tests++;
        if (bus.FetchValid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_no_fv got %b want 0", bus.FetchValid);
        end
        Rst = 1'b1;
        init_cnt = 0;
        repeat (4) tick();
        tests++;
        if (init_cnt !== 1 || fv_cnt !== fv0 || err_cnt !== err0 || done_cnt !== done0 || bus.Busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_release init=%0d fv=%0d err=%0d done=%0d busy=%b want 1/0/0/0/0",
                     init_cnt, fv_cnt - fv0, err_cnt - err0, done_cnt - done0, bus.Busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'hEE;
        bus.ReadData = 8'h00;
        bus.ClrReq = 1'b0;
        bus.LoadStart = 1'b0;
        bus.LoadBase = '0;
        bus.LoadLen = '0;
        bus.LoadValid = 1'b0;
        bus.LoadData = '0;
        bus.FetchReq = 1'b0;
        bus.FetchAddr = '0;

        test_reset();
        test_load_ok();
        test_load_err();
        test_priority();
        test_back_to_back(9'h1FE, 9'h1FF, 9'h010, 8'hA5, 8'h5A, 8'h3C, "loaded");
        test_clear_abort();
        test_reset_mid_fetch();

        tests++;
        if (overlap_cnt !== 0) begin
            fails++;
            $display("FAIL strobe_exclusive overlaps=%0d want 0", overlap_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_mem_controller.md
INSTR_MEM_CONTROLLER -- requirements
Module: instr_mem_controller

Interface
REQ-001 Parameters SHALL be: ADDR_W, 9, instruction memory address width; DATA_W, 8, instruction byte width.
REQ-002 Clk  in  1  single clock; all state changes on rising edge.
REQ-003 Rst  in  1  synchronous, active-low reset.
REQ-004 ClrReq  in  1  request to zero the whole memory.
REQ-005 LoadStart, LoadBase, LoadLen  in  1/9/10  start a program load of LoadLen bytes at LoadBase.
REQ-006 LoadValid, LoadData  in  1/8; LoadReady  out  1  loader byte-stream handshake.
REQ-007 LoadDone, LoadErr  out  1  one-cycle status pulses.
REQ-008 FetchReq, FetchAddr  in  1/9; FetchGnt  out  1  fetch request and grant.
REQ-009 FetchValid, FetchData  out  1/8  fetch response.
REQ-010 Busy  out  1  high whenever the state is not IDLE.
REQ-011 Addr, WriteData  out  9/8; WAIM, RAIM, InitAIM  out  1; ReadData  in  8  memory-side port.

Function
REQ-012 The FSM SHALL have states CLEAR, IDLE and LOAD.
REQ-013 CLEAR: InitAIM SHALL be registered high for exactly one cycle, then the FSM SHALL move to IDLE.
REQ-014 Priority in IDLE SHALL be ClrReq > LoadStart > FetchReq, evaluated each cycle.
REQ-015 FetchGnt SHALL be combinational: FetchReq AND IDLE AND NOT ClrReq AND NOT LoadStart.
REQ-016 Granted fetch at edge t: Addr<=FetchAddr and RAIM<=1 for one cycle. FetchValid SHALL be registered high for one cycle at edge t+2. FetchData SHALL equal ReadData (2-cycle latency).
REQ-017 Back-to-back grants SHALL be allowed every cycle, giving one FetchValid per cycle.
REQ-018 LoadStart in IDLE with LoadLen==0 or LoadBase+LoadLen>512 SHALL pulse LoadErr, leave the memory untouched and stay in IDLE.
REQ-019 A valid LoadStart SHALL latch the pointer (LoadBase) and the remaining count (LoadLen), then enter LOAD.
REQ-020 In LOAD, LoadReady SHALL be 1. Each LoadValid&LoadReady edge registers Addr<=ptr, WriteData<=LoadData and WAIM<=1 for one cycle, then ptr+1 and count-1.
REQ-021 Acceptance of the final byte SHALL pulse LoadDone at the same edge and return the FSM to IDLE. LoadReady SHALL be 0 in the next cycle.
REQ-022 ClrReq in LOAD SHALL abort the load, pulse LoadErr and enter CLEAR. Bytes already written stay until InitAIM.
REQ-023 FetchReq outside IDLE SHALL NOT be granted; the requester SHALL hold its request.
REQ-024 At most one of WAIM, RAIM and InitAIM SHALL be high in any cycle.
REQ-025 When they are not being driven, strobes SHALL be 0 and Addr/WriteData SHALL hold their last value.

Reset
REQ-026 While Rst=0 at an edge, all registered outputs SHALL be 0, count and ptr SHALL be 0, and the state SHALL be CLEAR.
REQ-027 The first edge with Rst=1 SHALL issue the CLEAR InitAIM pulse.
REQ-028 Reset mid-load or mid-fetch SHALL discard the pending FetchValid and the load without raising LoadDone or LoadErr.

Structure
REQ-029 The shared package SHALL hold the state encoding (CLEAR/IDLE/LOAD), ADDR_W, DATA_W and MEM_DEPTH=512.
REQ-030 A sub-module instr_fetch_pipe SHALL hold the 2-stage RAIM→FetchValid valid pipeline. The FSM, counters and muxes SHALL stay at the top level.

Verification
REQ-031 Release reset -> InitAIM pulses exactly once, then Busy=0 and FetchGnt follows FetchReq.
REQ-032 LoadStart base=0x1FE, len=2, bytes 0xA5 then 0x5A -> WAIM at 0x1FE and then 0x1FF, LoadDone pulses, and fetching 0x1FF returns 0x5A two cycles later.
REQ-033 LoadStart base=0x1FF, len=2 -> LoadErr pulses, no WAIM, state stays IDLE; the same happens with len=0.
REQ-034 LoadStart and FetchReq in the same IDLE cycle -> FetchGnt=0, LOAD entered; the fetch is granted in the cycle after LoadDone.
REQ-035 ClrReq after 3 of 8 load bytes -> LoadErr, InitAIM once, and a later fetch of those 3 addresses returns 0x00.
REQ-036 Rst=0 one cycle after a fetch grant -> no FetchValid, all outputs 0, then a single InitAIM after release.
